// File: rtl/io_ports_pkg.sv
// Shared constants and types for the 8080 IO input-port block: port numbers,
// button/DIP bit positions and the coin FSM state encoding.
package io_ports_pkg;

  localparam logic [7:0] PORT_INP0     = 8'd0;
  localparam logic [7:0] PORT_INP1     = 8'd1;
  localparam logic [7:0] PORT_INP2     = 8'd2;
  localparam logic [7:0] PORT_SHIFT_RD = 8'd3;

  localparam int NUM_BTN    = 10;
  localparam int BTN_COIN   = 0;
  localparam int BTN_START1 = 1;
  localparam int BTN_START2 = 2;
  localparam int BTN_FIRE1  = 3;
  localparam int BTN_LEFT1  = 4;
  localparam int BTN_RIGHT1 = 5;
  localparam int BTN_FIRE2  = 6;
  localparam int BTN_LEFT2  = 7;
  localparam int BTN_RIGHT2 = 8;
  localparam int BTN_TILT   = 9;

  localparam int DIP_SHIPS_LSB = 0;
  localparam int DIP_SHIPS_MSB = 1;
  localparam int DIP_BONUS     = 3;
  localparam int DIP_PORT0     = 4;
  localparam int DIP_COIN_INFO = 7;

  typedef enum logic [1:0] {
    COIN_IDLE,
    COIN_PULSE,
    COIN_WAIT_RELEASE
  } coin_state_t;

endpackage

// File: rtl/input_debounce.sv
// One cabinet button: 2-FF synchroniser on the raw active-low line, then a
// counter that accepts a new level only after DEBOUNCE_CYCLES stable cycles.
module input_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic btn_n,
  output logic pressed
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

  logic [1:0]       sync_n;
  logic             synced;
  logic [CNT_W-1:0] cnt;

  assign synced = ~sync_n[1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // NOTE: raw line is active-low, so loading 1s here means "released"
      // after inversion; a button held through reset must re-qualify.
      sync_n  <= 2'b11;
      pressed <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      sync_n <= {sync_n[0], btn_n};
      if (synced == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pressed <= synced;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/io_input_ports.sv
// CPU IN-instruction responder for ports 0-3: debounced controls, synchronised
// DIPs, a stretched coin credit and the bitshift result, with 1-cycle latency.
module io_input_ports
  import io_ports_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES   = 16'd50000,
  parameter logic [23:0] COIN_PULSE_CYCLES = 24'd1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rd,
  input  logic [7:0] i_port,
  input  logic [7:0] i_shift_data,
  input  logic [9:0] i_btn_n,
  input  logic [7:0] i_dip,
  output logic [7:0] o_data,
  output logic       o_rd_valid
);

  logic [NUM_BTN-1:0] pressed;
  logic [7:0]         dip_meta;
  logic [7:0]         dip_s;
  logic               dip_unused;
  coin_state_t        coin_state;
  logic [23:0]        pulse_cnt;
  logic               coin_prev;
  logic               credit;
  logic [7:0]         port_image;

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .btn_n  (i_btn_n[b]),
      .pressed(pressed[b])
    );
  end

  // DIPs are static in practice, so they are synchronised but not debounced.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dip_meta <= '0;
      dip_s    <= '0;
    end else begin
      dip_meta <= i_dip;
      dip_s    <= dip_meta;
    end
  end

  assign dip_unused = ^{dip_s[6:5], dip_s[2]};

  // One credit pulse per press: a held coin parks in WAIT_RELEASE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      coin_state <= COIN_IDLE;
      pulse_cnt  <= '0;
      coin_prev  <= 1'b0;
      credit     <= 1'b0;
    end else begin
      coin_prev <= pressed[BTN_COIN];
      case (coin_state)
        COIN_IDLE: begin
          if (pressed[BTN_COIN] && !coin_prev) begin
            pulse_cnt  <= COIN_PULSE_CYCLES - 24'd1;
            credit     <= 1'b1;
            coin_state <= COIN_PULSE;
          end
        end
        COIN_PULSE: begin
          if (pulse_cnt == '0) begin
            credit     <= 1'b0;
            coin_state <= pressed[BTN_COIN] ? COIN_WAIT_RELEASE : COIN_IDLE;
          end else begin
            pulse_cnt <= pulse_cnt - 24'd1;
          end
        end
        COIN_WAIT_RELEASE: begin
          if (!pressed[BTN_COIN]) coin_state <= COIN_IDLE;
        end
        default: begin
          credit     <= 1'b0;
          coin_state <= COIN_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns port_image and no latch forms.
    port_image = 8'h00;
    case (i_port)
      PORT_INP0: port_image = {1'b0, pressed[BTN_RIGHT1], pressed[BTN_LEFT1],
                               pressed[BTN_FIRE1], 3'b111, dip_s[DIP_PORT0]};
      PORT_INP1: port_image = {1'b0, pressed[BTN_RIGHT1], pressed[BTN_LEFT1],
                               pressed[BTN_FIRE1], 1'b1, pressed[BTN_START1],
                               pressed[BTN_START2], credit};
      PORT_INP2: port_image = {dip_s[DIP_COIN_INFO], pressed[BTN_RIGHT2],
                               pressed[BTN_LEFT2], pressed[BTN_FIRE2],
                               dip_s[DIP_BONUS], pressed[BTN_TILT],
                               dip_s[DIP_SHIPS_MSB:DIP_SHIPS_LSB]};
      PORT_SHIFT_RD: port_image = i_shift_data;
      default: port_image = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data     <= 8'h00;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= i_rd;
      if (i_rd) o_data <= port_image;
    end
  end

endmodule

// File: tb/tb_io_input_ports.sv
// Self-checking bench for io_input_ports: directed scenarios with fixed expected
// bytes plus a randomized phase checked every cycle against a behavioural model.
module tb_io_input_ports;

  localparam int D = 4;
  localparam int P = 8;

  logic       i_clk;
  logic       i_rst;
  logic       i_rd;
  logic [7:0] i_port;
  logic [7:0] i_shift_data;
  logic [9:0] i_btn_n;
  logic [7:0] i_dip;
  logic [7:0] o_data;
  logic       o_rd_valid;

  io_input_ports #(
    .DEBOUNCE_CYCLES  (16'd4),
    .COIN_PULSE_CYCLES(24'd8)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rd        (i_rd),
    .i_port      (i_port),
    .i_shift_data(i_shift_data),
    .i_btn_n     (i_btn_n),
    .i_dip       (i_dip),
    .o_data      (o_data),
    .o_rd_valid  (o_rd_valid)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: per-edge history of raw pressed levels and DIPs; a
  // button flips once its 2-cycle-delayed level has disagreed for D edges.
  logic [9:0] hist_btn[$];
  logic [7:0] hist_dip[$];
  logic [9:0] m_pressed;
  int         m_pulse_left;
  bit         m_wait_release;
  logic [7:0] m_data;
  logic       m_valid;

  function automatic logic [7:0] image(input logic [7:0] port, input logic [9:0] p,
                                       input logic credit, input logic [7:0] dip,
                                       input logic [7:0] shift);
    case (port)
      8'd0:    return {1'b0, p[5], p[4], p[3], 3'b111, dip[4]};
      8'd1:    return {1'b0, p[5], p[4], p[3], 1'b1, p[1], p[2], credit};
      8'd2:    return {dip[7], p[8], p[7], p[6], dip[3], p[9], dip[1:0]};
      8'd3:    return shift;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_edge();
    logic [9:0] p;
    logic [9:0] nxt;
    logic       credit;
    int         n;
    bit         all_diff;
    if (i_rst) begin
      hist_btn.delete();
      hist_dip.delete();
      for (int i = 0; i < 8; i++) begin
        hist_btn.push_back('0);
        hist_dip.push_back('0);
      end
      m_pressed      = '0;
      m_pulse_left   = 0;
      m_wait_release = 0;
      m_data         = 8'h00;
      m_valid        = 1'b0;
      return;
    end
    n      = hist_btn.size();
    p      = m_pressed;
    credit = (m_pulse_left > 0);
    m_valid = i_rd;
    if (i_rd) m_data = image(i_port, p, credit, hist_dip[n-2], i_shift_data);
    nxt = p;
    for (int b = 0; b < 10; b++) begin
      all_diff = 1;
      for (int j = 0; j < D; j++)
        if (hist_btn[n-2-j][b] == p[b]) all_diff = 0;
      if (all_diff) nxt[b] = ~p[b];
    end
    if (m_pulse_left > 0) begin
      m_pulse_left--;
      if (m_pulse_left == 0) m_wait_release = p[0];
    end else if (m_wait_release) begin
      if (!p[0]) m_wait_release = 0;
    end else if (p[0]) begin
      m_pulse_left = P;
    end
    m_pressed = nxt;
    hist_btn.push_back(~i_btn_n);
    hist_dip.push_back(i_dip);
    while (hist_btn.size() > 8) void'(hist_btn.pop_front());
    while (hist_dip.size() > 8) void'(hist_dip.pop_front());
  endtask

  bit model_live = 0;

  task automatic tick();
    @(posedge i_clk);
    model_edge();
    model_live = 1;
    @(negedge i_clk);
    check("model_valid", o_rd_valid, m_valid);
    check("model_data", o_data, m_data);
  endtask

  task automatic read_port(input logic [7:0] port, output logic [7:0] d, output logic v);
    i_rd   = 1'b1;
    i_port = port;
    tick();
    d = o_data;
    v = o_rd_valid;
    i_rd = 1'b0;
  endtask

  logic [7:0] d;
  logic       v;
  int         cnt;
  bit         seen;
  logic [7:0] rbuf[10];

  initial begin
    i_rst = 1'b1; i_rd = 1'b0; i_port = '0; i_shift_data = '0;
    i_btn_n = '1; i_dip = '0;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();

    // Reset values
    read_port(8'd1, d, v);
    check("rst_port1", d, 8'h08);
    check("rst_valid", v, 1'b1);
    tick();
    check("valid_once", o_rd_valid, 1'b0);
    read_port(8'd0, d, v);
    check("rst_port0", d, 8'h0E);

    // Debounce: short glitch is filtered, long hold is accepted
    i_btn_n[3] = 1'b0;
    repeat (2) tick();
    i_btn_n[3] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      read_port(8'd1, d, v);
      check("glitch_port1", d, 8'h08);
    end
    i_btn_n[3] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      read_port(8'd1, d, v);
      rbuf[k] = d;
    end
    check("hold_early", rbuf[1], 8'h08);
    check("hold_port1", rbuf[6], 8'h18);
    check("hold_late", rbuf[9], 8'h18);
    i_btn_n[3] = 1'b1;
    repeat (10) tick();

    // Coin: held coin gives one 8-cycle pulse, re-press gives another
    for (int rep = 0; rep < 2; rep++) begin
      i_btn_n[0] = 1'b0;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
        read_port(8'd1, d, v);
        if (d[0]) cnt++;
      end
      check("coin_pulse_len", cnt, P);
      check("coin_held_low", d[0], 1'b0);
      i_btn_n[0] = 1'b1;
      repeat (12) tick();
    end

    // Port mux
    i_shift_data = 8'hA5;
    read_port(8'd3, d, v);
    check("port3_shift", d, 8'hA5);
    i_dip = 8'h8B;
    i_btn_n[9] = 1'b0;
    repeat (8) tick();
    read_port(8'd2, d, v);
    check("port2_dip_tilt", d, 8'h8F);
    read_port(8'd7, d, v);
    check("port7_zero", d, 8'h00);
    i_btn_n[9] = 1'b1;
    i_dip = 8'h00;
    repeat (10) tick();

    // Back-to-back reads on ports 1, 2, 3
    i_shift_data = 8'h3C;
    i_rd = 1'b1;
    i_port = 8'd1; tick();
    check("b2b_v1", o_rd_valid, 1'b1); check("b2b_d1", o_data, 8'h08);
    i_port = 8'd2; tick();
    check("b2b_v2", o_rd_valid, 1'b1); check("b2b_d2", o_data, 8'h00);
    i_port = 8'd3; tick();
    check("b2b_v3", o_rd_valid, 1'b1); check("b2b_d3", o_data, 8'h3C);
    i_rd = 1'b0;
    tick();
    check("b2b_idle", o_rd_valid, 1'b0);
    check("b2b_hold", o_data, 8'h3C);

    // Reset in the middle of a coin pulse, fire1 held through reset
    i_btn_n[0] = 1'b0;
    i_btn_n[3] = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      read_port(8'd1, d, v);
      if (d[0]) seen = 1;
    end
    check("coin_start_seen", seen, 1'b1);
    tick();
    i_rst = 1'b1;
    i_btn_n[0] = 1'b1;
    tick();
    i_rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      read_port(8'd1, d, v);
      rbuf[k] = d;
    end
    check("rst_credit_drop", rbuf[0], 8'h08);
    check("rst_fire_pending", rbuf[5], 8'h08);
    check("rst_fire_redeb", rbuf[6], 8'h18);
    i_btn_n[3] = 1'b1;
    repeat (10) tick();

    // Randomized phase against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 4) == 0) begin
        int idx;
        idx = $urandom_range(0, 9);
        i_btn_n[idx] = ~i_btn_n[idx];
      end
      if ($urandom_range(0, 49) == 0) i_dip = 8'($urandom);
      i_shift_data = 8'($urandom);
      i_rd = ($urandom_range(0, 2) == 0);
      i_port = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
      i_rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    i_rst = 1'b0;
    i_rd = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
